// File: rtl/note_window_shifter_if.sv
// Request, ROM-port and window-output bundle for note_window_shifter.
// Slave modport is the shifter side; master is the song-player / ROM side.
interface note_window_shifter_if #(
    parameter int NOTE_W = 16,
    parameter int LANES  = 3,
    parameter int WIN    = 5,
    parameter int ADDR_W = 9,
    parameter int SONG_W = 2
);
    logic                          note_advance;
    logic                          note_reverse;
    logic [SONG_W-1:0]             song_sel;
    logic                          loop_en;
    logic [ADDR_W-1:0]             rom_addr;
    logic [NOTE_W-1:0]             rom_data;
    logic [LANES*WIN*NOTE_W-1:0]   win_notes;
    logic [WIN-1:0]                valid;
    logic [ADDR_W-1:0]             pos;
    logic [ADDR_W-1:0]             step_count;
    logic                          busy;

    modport slave (
        input  note_advance, note_reverse, song_sel, loop_en, rom_data,
        output rom_addr, win_notes, valid, pos, step_count, busy
    );

    modport master (
        output note_advance, note_reverse, song_sel, loop_en, rom_data,
        input  rom_addr, win_notes, valid, pos, step_count, busy
    );
endinterface

// File: rtl/note_window_shifter.sv
// WIN x LANES note window around the current song step, fetched from a 1-cycle sync ROM.
// Shift commits LANES+2 cycles after accept, song load 2+WIN*LANES+2; requests ignored while busy.
module note_window_shifter #(
    parameter int NOTE_W     = 16,
    parameter int LANES      = 3,
    parameter int WIN        = 5,
    parameter int ADDR_W     = 9,
    parameter int SONG_W     = 2,
    parameter int SONG_SHIFT = 7,
    parameter int MAX_STEPS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    note_window_shifter_if.slave bus
);
    localparam int C      = WIN / 2;
    localparam int WORDS  = WIN * LANES;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam int COL_W  = $clog2(WIN + 1);
    localparam int LANE_W = $clog2(LANES + 1);
    localparam int T_W    = ADDR_W + 2;
    localparam int BUS_W  = LANES * WIN * NOTE_W;

    typedef enum logic [2:0] {
        S_HDR, S_HDR_WAIT, S_FILL, S_IDLE, S_SHIFT, S_COMMIT
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SONG_W-1:0]   r_song;
    logic                r_loop;
    logic [ADDR_W-1:0]   r_n, r_pos_n;
    logic [CNT_W-1:0]    r_cnt;
    logic [COL_W-1:0]    r_col, r_cap_col;
    logic [LANE_W-1:0]   r_lane, r_cap_lane;
    logic                r_cap_vld;
    logic [BUS_W-1:0]    r_stg_notes, r_win_notes;
    logic [WIN-1:0]      r_stg_vld, r_valid;
    logic [ADDR_W-1:0]   r_pos, r_step_count;

    logic                w_busy;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic                w_song_chg, w_adv_acc, w_rev_acc, w_rebuild;
    logic                w_n_zero, w_at_start, w_at_end;
    logic [CNT_W-1:0]    w_total;
    logic                w_issue;
    logic signed [T_W-1:0] w_t_raw, w_t_mod, w_n_s;
    logic                w_col_ok;
    logic [ADDR_W-1:0]   w_step, w_base_live, w_base, w_note_addr;
    logic [BUS_W-1:0]    w_stg_adv, w_stg_rev;

    assign w_n_zero   = (r_n == '0);
    assign w_at_start = (r_pos_n == '0);
    assign w_at_end   = (r_pos_n == r_n - ADDR_W'(1));
    assign w_song_chg = (bus.song_sel != r_song);
    assign w_adv_acc  = bus.note_advance & ~bus.note_reverse & ~w_n_zero & (~w_at_end | bus.loop_en);
    assign w_rev_acc  = bus.note_reverse & ~bus.note_advance & ~w_n_zero & (~w_at_start | bus.loop_en);
    // Shifted columns only stay correct if they were built under the same wrap mode.
    assign w_rebuild  = (bus.loop_en != r_loop);

    assign w_total = (r_state == S_FILL) ? CNT_W'(WORDS) : CNT_W'(LANES);
    assign w_issue = ((r_state == S_FILL) || (r_state == S_SHIFT)) && (r_cnt != w_total);

    // Step index of the column being fetched; the wrap loop only needs C passes.
    always_comb begin
        w_n_s   = signed'({2'b00, r_n});
        w_t_raw = signed'({2'b00, r_pos_n}) + signed'(T_W'(r_col)) - T_W'(C);
        w_t_mod = w_t_raw;
        for (int i = 0; i < C; i++) begin
            if (w_t_mod[T_W-1])
                w_t_mod = w_t_mod + w_n_s;
            else if (w_t_mod >= w_n_s)
                w_t_mod = w_t_mod - w_n_s;
        end
        w_col_ok = !w_n_zero && (r_loop || (!w_t_raw[T_W-1] && (w_t_raw < w_n_s)));
        w_step   = r_loop ? w_t_mod[ADDR_W-1:0] : w_t_raw[ADDR_W-1:0];
    end

    assign w_base_live = ADDR_W'(bus.song_sel) << SONG_SHIFT;
    assign w_base      = ADDR_W'(r_song) << SONG_SHIFT;
    assign w_note_addr = w_base + ADDR_W'(1) + ADDR_W'(w_step * LANES) + ADDR_W'(r_lane);

    always_comb begin
        w_stg_adv = '0;
        w_stg_rev = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < WIN - 1; k++) begin
                w_stg_adv[(l*WIN+k)*NOTE_W +: NOTE_W]   = r_stg_notes[(l*WIN+k+1)*NOTE_W +: NOTE_W];
                w_stg_rev[(l*WIN+k+1)*NOTE_W +: NOTE_W] = r_stg_notes[(l*WIN+k)*NOTE_W +: NOTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_HDR;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_rom_addr  = '0;
        case (r_state)
            S_HDR: begin
                w_state_nxt = S_HDR_WAIT;
                w_rom_addr  = w_base_live;
            end
            S_HDR_WAIT: w_state_nxt = S_FILL;
            S_FILL, S_SHIFT: begin
                if (w_issue && w_col_ok)
                    w_rom_addr = w_note_addr;
                if (!w_issue)
                    w_state_nxt = S_COMMIT;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_song_chg)
                    w_state_nxt = S_HDR;
                else if (w_adv_acc || w_rev_acc)
                    w_state_nxt = w_rebuild ? S_FILL : S_SHIFT;
            end
            default: w_state_nxt = S_HDR;
        endcase
        if (!rst)
            w_rom_addr = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_song       <= '0;
            r_loop       <= 1'b0;
            r_n          <= '0;
            r_pos_n      <= '0;
            r_cnt        <= '0;
            r_col        <= '0;
            r_lane       <= '0;
            r_cap_col    <= '0;
            r_cap_lane   <= '0;
            r_cap_vld    <= 1'b0;
            r_stg_notes  <= '0;
            r_stg_vld    <= '0;
            r_win_notes  <= '0;
            r_valid      <= '0;
            r_pos        <= '0;
            r_step_count <= '0;
        end else begin
            r_cap_vld <= 1'b0;
            if (r_cap_vld)
                r_stg_notes[(int'(r_cap_lane)*WIN + int'(r_cap_col))*NOTE_W +: NOTE_W] <= bus.rom_data;
            case (r_state)
                S_HDR: begin
                    r_song  <= bus.song_sel;
                    r_loop  <= bus.loop_en;
                    r_pos_n <= '0;
                end
                S_HDR_WAIT: begin
                    r_n <= (bus.rom_data[ADDR_W-1:0] > ADDR_W'(MAX_STEPS)) ?
                           ADDR_W'(MAX_STEPS) : bus.rom_data[ADDR_W-1:0];
                    r_cnt       <= '0;
                    r_col       <= '0;
                    r_lane      <= '0;
                    r_stg_notes <= '0;
                    r_stg_vld   <= '0;
                end
                S_FILL, S_SHIFT: begin
                    if (w_issue) begin
                        r_cap_vld        <= w_col_ok;
                        r_cap_col        <= r_col;
                        r_cap_lane       <= r_lane;
                        r_stg_vld[r_col] <= w_col_ok;
                        r_cnt            <= r_cnt + 1'b1;
                        if (r_lane == LANE_W'(LANES - 1)) begin
                            r_lane <= '0;
                            r_col  <= r_col + 1'b1;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (!w_song_chg && (w_adv_acc || w_rev_acc)) begin
                        r_loop <= bus.loop_en;
                        r_cnt  <= '0;
                        r_lane <= '0;
                        if (w_adv_acc)
                            r_pos_n <= w_at_end ? '0 : r_pos_n + 1'b1;
                        else
                            r_pos_n <= w_at_start ? r_n - 1'b1 : r_pos_n - 1'b1;
                        if (w_rebuild) begin
                            r_col       <= '0;
                            r_stg_notes <= '0;
                            r_stg_vld   <= '0;
                        end else if (w_adv_acc) begin
                            r_col       <= COL_W'(WIN - 1);
                            r_stg_notes <= w_stg_adv;
                            r_stg_vld   <= {1'b0, r_stg_vld[WIN-1:1]};
                        end else begin
                            r_col       <= '0;
                            r_stg_notes <= w_stg_rev;
                            r_stg_vld   <= {r_stg_vld[WIN-2:0], 1'b0};
                        end
                    end
                end
                S_COMMIT: begin
                    r_win_notes  <= r_stg_notes;
                    r_valid      <= r_stg_vld;
                    r_pos        <= r_pos_n;
                    r_step_count <= r_n;
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr   = w_rom_addr;
    assign bus.busy       = w_busy;
    assign bus.win_notes  = r_win_notes;
    assign bus.valid      = r_valid;
    assign bus.pos        = r_pos;
    assign bus.step_count = r_step_count;
endmodule

// File: tb/tb_note_window_shifter.sv
// Self-checking bench for note_window_shifter: vector table + scoreboard queue, ROM model, reset corners.
module tb_note_window_shifter;
    localparam int NOTE_W = 16;
    localparam int LANES  = 3;
    localparam int WIN    = 5;
    localparam int ADDR_W = 9;
    localparam int SONG_W = 2;
    localparam int C      = WIN / 2;
    localparam int BUS_W  = LANES * WIN * NOTE_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    note_window_shifter_if #(.NOTE_W(NOTE_W), .LANES(LANES), .WIN(WIN),
                             .ADDR_W(ADDR_W), .SONG_W(SONG_W)) bus ();

    note_window_shifter #(.NOTE_W(NOTE_W), .LANES(LANES), .WIN(WIN), .ADDR_W(ADDR_W),
                          .SONG_W(SONG_W), .SONG_SHIFT(7), .MAX_STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NOTE_W-1:0] mem [0:511];
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    typedef struct {
        logic adv;
        logic rev;
        logic lp;
        int   song;
        logic exp_busy;
        int   exp_lat;
        int   exp_pos;
        int   exp_n;
    } vec_t;

    typedef struct {
        int   song;
        int   n;
        int   pos;
        logic lp;
        logic busy;
        int   lat;
    } exp_t;

    vec_t vt [14];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    logic win_lp   = 1'b0;
    int   win_song = 0;

    task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [NOTE_W-1:0] note_val(input int song, input int s, input int l);
        logic [NOTE_W-1:0] v;
        v = NOTE_W'(s * 256 + l);
        if (song == 2)
            v = v + 16'h2000;
        return v;
    endfunction

    function automatic void model(input int song, input int n, input int pos, input logic lp,
                                  output logic [BUS_W-1:0] notes, output logic [WIN-1:0] vld);
        int  t;
        bit  ok;
        notes = '0;
        vld   = '0;
        for (int k = 0; k < WIN; k++) begin
            t  = pos + k - C;
            ok = 1'b0;
            if (n > 0) begin
                if (lp) begin
                    t  = ((t % n) + n) % n;
                    ok = 1'b1;
                end else begin
                    ok = (t >= 0) && (t < n);
                end
            end
            if (ok) begin
                vld[k] = 1'b1;
                for (int l = 0; l < LANES; l++)
                    notes[(l*WIN+k)*NOTE_W +: NOTE_W] = note_val(song, t, l);
            end
        end
    endfunction

    task automatic check_window(input string tag, input int song, input int n, input int pos, input logic lp);
        logic [BUS_W-1:0] en;
        logic [WIN-1:0]   ev;
        model(song, n, pos, lp, en, ev);
        chk({tag, ".pos"}, BUS_W'(bus.pos), BUS_W'(pos));
        chk({tag, ".step_count"}, BUS_W'(bus.step_count), BUS_W'(n));
        chk({tag, ".valid"}, BUS_W'(bus.valid), BUS_W'(ev));
        chk({tag, ".win_notes"}, bus.win_notes, en);
    endtask

    // Counts edges until busy drops; returns 999 if the budget runs out.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (bus.busy)
            cyc = 999;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t  e;
        int    cyc;
        logic  saw;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.note_advance = v.adv;
        bus.note_reverse = v.rev;
        bus.loop_en      = v.lp;
        bus.song_sel     = SONG_W'(v.song);
        e.song = v.exp_busy ? v.song : win_song;
        e.lp   = v.exp_busy ? v.lp : win_lp;
        e.n    = v.exp_n;
        e.pos  = v.exp_pos;
        e.busy = v.exp_busy;
        e.lat  = v.exp_lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.note_advance = 1'b0;
        bus.note_reverse = 1'b0;
        saw = bus.busy;
        cyc = 0;
        if (saw) begin
            wait_idle(cyc);
        end else begin
            repeat (8) begin
                @(posedge clk);
                #1;
                if (bus.busy) saw = 1'b1;
            end
            if (saw) wait_idle(cyc);
        end
        e = sb.pop_front();
        chk({tag, ".busy_seen"}, BUS_W'(saw), BUS_W'(e.busy));
        if (e.busy && e.lat > 0)
            chk({tag, ".latency"}, BUS_W'(cyc), BUS_W'(e.lat));
        check_window(tag, e.song, e.n, e.pos, e.lp);
        if (e.busy) begin
            win_lp   = e.lp;
            win_song = e.song;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int a = 0; a < 512; a++) mem[a] = 16'hBEEF;
        mem[0] = 16'd4;
        for (int s = 0; s < 4; s++)
            for (int l = 0; l < LANES; l++) mem[1 + s*LANES + l] = note_val(0, s, l);
        mem[256] = 16'd2;
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < LANES; l++) mem[257 + s*LANES + l] = note_val(2, s, l);

        //           adv   rev   lp    song busy  lat pos n
        vt[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 5,  1, 4};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 5,  2, 4};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 5,  3, 4};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0,  3, 4};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 5,  2, 4};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 5,  1, 4};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 5,  0, 4};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 0,  0, 4};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 17, 3, 4};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 5,  0, 4};
        vt[10] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 0,  0, 4};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 19, 0, 2};
        vt[12] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 5,  1, 2};
        vt[13] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 0,  1, 2};

        bus.note_advance = 1'b0;
        bus.note_reverse = 1'b0;
        bus.song_sel     = '0;
        bus.loop_en      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.win_notes", bus.win_notes, '0);
        chk("reset.valid", BUS_W'(bus.valid), '0);
        chk("reset.pos", BUS_W'(bus.pos), '0);
        chk("reset.step_count", BUS_W'(bus.step_count), '0);
        chk("reset.busy", BUS_W'(bus.busy), BUS_W'(1));
        chk("reset.rom_addr", BUS_W'(bus.rom_addr), '0);

        @(negedge clk);
        rst = 1'b1;
        wait_idle(cyc);
        chk("load0.latency", BUS_W'(cyc), BUS_W'(19));
        chk("load0.valid_lit", BUS_W'(bus.valid), BUS_W'(5'b11100));
        chk("load0.centre_l1", BUS_W'(bus.win_notes[(1*WIN+2)*NOTE_W +: NOTE_W]), BUS_W'(16'h0001));
        chk("load0.col4_l2", BUS_W'(bus.win_notes[(2*WIN+4)*NOTE_W +: NOTE_W]), BUS_W'(16'h0202));
        chk("load0.col0_l0", BUS_W'(bus.win_notes[0 +: NOTE_W]), '0);
        chk("load0.col1_l2", BUS_W'(bus.win_notes[(2*WIN+1)*NOTE_W +: NOTE_W]), '0);
        check_window("load0", 0, 4, 0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vt[i], i);
            if (i == 2) chk("pos3.valid_lit", BUS_W'(bus.valid), BUS_W'(5'b00111));
            if (i == 9) begin
                chk("wrap.valid_lit", BUS_W'(bus.valid), BUS_W'(5'b11111));
                chk("wrap.col0_l0", BUS_W'(bus.win_notes[0 +: NOTE_W]), BUS_W'(16'h0200));
                chk("wrap.col4_l0", BUS_W'(bus.win_notes[4*NOTE_W +: NOTE_W]), BUS_W'(16'h0200));
            end
        end

        // Reset in the middle of a shift on song 2, then reload song 0.
        @(negedge clk);
        bus.note_reverse = 1'b1;
        @(posedge clk);
        #1;
        bus.note_reverse = 1'b0;
        chk("midshift.accepted", BUS_W'(bus.busy), BUS_W'(1));
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        bus.song_sel = '0;
        @(posedge clk);
        #1;
        chk("midrst.win_notes", bus.win_notes, '0);
        chk("midrst.valid", BUS_W'(bus.valid), '0);
        chk("midrst.pos", BUS_W'(bus.pos), '0);
        chk("midrst.step_count", BUS_W'(bus.step_count), '0);
        chk("midrst.busy", BUS_W'(bus.busy), BUS_W'(1));
        chk("midrst.rom_addr", BUS_W'(bus.rom_addr), '0);
        @(negedge clk);
        rst = 1'b1;
        wait_idle(cyc);
        chk("reload.latency", BUS_W'(cyc), BUS_W'(19));
        check_window("reload", 0, 4, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
